// File: rtl/sync_sig_filter.sv
// Multi-flop synchroniser with optional whole-word stability filter and
// per-bit rise/fall pulse outputs, all in the dst_clk domain.
module sync_sig_filter #(
    parameter int unsigned      WIDTH         = 1,
    parameter int unsigned      STAGES        = 2,
    parameter logic [WIDTH-1:0] RST_VAL       = {WIDTH{1'b0}},
    parameter int unsigned      STABLE_CYCLES = 0
) (
    input  logic             dst_clk,
    input  logic             dst_rst,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    localparam int unsigned      CNT_W   = (STABLE_CYCLES == 0) ? 1 : $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    if (STAGES < 2) begin : g_stages_check
        $error("sync_sig_filter: STAGES must be >= 2");
    end

    // Metastability chain; each flop must stay a distinct, un-retimed register.
    (* ASYNC_REG = "TRUE", KEEP = "TRUE" *)
    logic [STAGES-1:0][WIDTH-1:0] stage;

    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] hist;
    logic [WIDTH-1:0] out_prev;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             upd;

    assign sync_q = stage[STAGES-1];

    always_ff @(posedge dst_clk) begin
        if (dst_rst) begin
            stage <= {STAGES{RST_VAL}};
        end else begin
            stage <= {stage[STAGES-2:0], in};
        end
    end

    // Count how long the synchronised word has held; saturate at CNT_MAX.
    always_comb begin
        cnt_next = '0;
        upd      = 1'b0;
        if (sync_q != hist) begin
            cnt_next = '0;
        end else if (cnt == CNT_MAX) begin
            cnt_next = CNT_MAX;
        end else begin
            cnt_next = cnt + CNT_W'(1);
        end
        upd = (cnt_next == CNT_MAX);
    end

    always_ff @(posedge dst_clk) begin
        if (dst_rst) begin
            hist     <= RST_VAL;
            cnt      <= CNT_MAX;
            out      <= RST_VAL;
            out_prev <= RST_VAL;
        end else begin
            hist     <= sync_q;
            cnt      <= cnt_next;
            out_prev <= out;
            if (upd) begin
                out <= sync_q;
            end
        end
    end

    // out and out_prev reset together, so no pulse appears on reset entry or release.
    assign rise    = out & ~out_prev;
    assign fall    = ~out & out_prev;
    assign changed = |(out ^ out_prev);

endmodule

// File: tb/tb_sync_sig_filter.sv
// Directed bench for sync_sig_filter: several instances cover reset value,
// latency, glitch rejection, bus skew, mid-flight reset and an unfiltered sweep.
module tb_sync_sig_filter;

    logic dst_clk = 1'b0;
    always #5 dst_clk = ~dst_clk;

    int errors = 0;
    int checks = 0;

    // A: WIDTH=4, RST_VAL=1010, S=0, STAGES=2
    logic       rst_a;
    logic [3:0] in_a, out_a, rise_a, fall_a;
    logic       chg_a;
    // B: WIDTH=1, S=3, STAGES=2
    logic rst_b, in_b, out_b, rise_b, fall_b, chg_b;
    // C: WIDTH=8, S=2, STAGES=2
    logic       rst_c;
    logic [7:0] in_c, out_c, rise_c, fall_c;
    logic       chg_c;
    // D: WIDTH=1, S=5, STAGES=2
    logic rst_d, in_d, out_d, rise_d, fall_d, chg_d;
    // E: WIDTH=4, S=0, STAGES=3
    logic       rst_e;
    logic [3:0] in_e, out_e, rise_e, fall_e;
    logic       chg_e;

    sync_sig_filter #(.WIDTH(4), .STAGES(2), .RST_VAL(4'b1010), .STABLE_CYCLES(0)) u_a (
        .dst_clk(dst_clk), .dst_rst(rst_a), .in(in_a), .out(out_a),
        .rise(rise_a), .fall(fall_a), .changed(chg_a));
    sync_sig_filter #(.WIDTH(1), .STAGES(2), .RST_VAL(1'b0), .STABLE_CYCLES(3)) u_b (
        .dst_clk(dst_clk), .dst_rst(rst_b), .in(in_b), .out(out_b),
        .rise(rise_b), .fall(fall_b), .changed(chg_b));
    sync_sig_filter #(.WIDTH(8), .STAGES(2), .RST_VAL(8'h00), .STABLE_CYCLES(2)) u_c (
        .dst_clk(dst_clk), .dst_rst(rst_c), .in(in_c), .out(out_c),
        .rise(rise_c), .fall(fall_c), .changed(chg_c));
    sync_sig_filter #(.WIDTH(1), .STAGES(2), .RST_VAL(1'b0), .STABLE_CYCLES(5)) u_d (
        .dst_clk(dst_clk), .dst_rst(rst_d), .in(in_d), .out(out_d),
        .rise(rise_d), .fall(fall_d), .changed(chg_d));
    sync_sig_filter #(.WIDTH(4), .STAGES(3), .RST_VAL(4'b0000), .STABLE_CYCLES(0)) u_e (
        .dst_clk(dst_clk), .dst_rst(rst_e), .in(in_e), .out(out_e),
        .rise(rise_e), .fall(fall_e), .changed(chg_e));

    task automatic tick();
        @(posedge dst_clk);
        #1;
    endtask

    task automatic test_reset();
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if ({out_a, rise_a, fall_a, chg_a} !== {4'b1010, 4'b0000, 4'b0000, 1'b0}) begin
                errors++;
                $display("FAIL reset_hold k=%0d {out,rise,fall,chg}=%b required %b", k,
                         {out_a, rise_a, fall_a, chg_a}, {4'b1010, 4'b0000, 4'b0000, 1'b0});
            end
        end
        checks++;
        if ({out_b, out_c, out_d, out_e} !== 14'h0) begin
            errors++;
            $display("FAIL reset_others outs=%h required 0", {out_b, out_c, out_d, out_e});
        end
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; rst_d = 1'b0; rst_e = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            checks++;
            if ({out_a, rise_a, fall_a, chg_a} !== {4'b1010, 4'b0000, 4'b0000, 1'b0}) begin
                errors++;
                $display("FAIL reset_release k=%0d {out,rise,fall,chg}=%b required %b", k,
                         {out_a, rise_a, fall_a, chg_a}, {4'b1010, 4'b0000, 4'b0000, 1'b0});
            end
        end
        checks++;
        if ({chg_b, chg_c, chg_d, chg_e} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_no_pulse changed=%b required 0000", {chg_b, chg_c, chg_d, chg_e});
        end
    endtask

    // Bits 3 fall and 2 rise in the same update.
    task automatic test_simultaneous();
        logic [12:0] exp;
        in_a = 4'b0110;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 3)     exp = {4'b0110, 4'b0100, 4'b1000, 1'b1};
            else if (k > 3) exp = {4'b0110, 4'b0000, 4'b0000, 1'b0};
            else            exp = {4'b1010, 4'b0000, 4'b0000, 1'b0};
            checks++;
            if ({out_a, rise_a, fall_a, chg_a} !== exp) begin
                errors++;
                $display("FAIL simultaneous k=%0d {out,rise,fall,chg}=%b required %b", k,
                         {out_a, rise_a, fall_a, chg_a}, exp);
            end
        end
    endtask

    task automatic test_latency();
        logic [3:0] exp;
        in_b = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            exp = {k >= 6, k == 6, 1'b0, k == 6};
            checks++;
            if ({out_b, rise_b, fall_b, chg_b} !== exp) begin
                errors++;
                $display("FAIL latency k=%0d {out,rise,fall,chg}=%b required %b", k,
                         {out_b, rise_b, fall_b, chg_b}, exp);
            end
        end
    endtask

    task automatic test_glitch();
        logic [3:0] exp;
        in_b = 1'b0;
        for (int k = 1; k <= 12; k++) tick();
        checks++;
        if (out_b !== 1'b0) begin
            errors++;
            $display("FAIL glitch_settle out=%b required 0", out_b);
        end
        // Three-cycle pulse: must be swallowed.
        in_b = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (k == 3) in_b = 1'b0;
            checks++;
            if ({out_b, rise_b, fall_b, chg_b} !== 4'b0000) begin
                errors++;
                $display("FAIL glitch3 k=%0d {out,rise,fall,chg}=%b required 0000", k,
                         {out_b, rise_b, fall_b, chg_b});
            end
        end
        // Four-cycle pulse: must pass as a four-cycle high on out.
        in_b = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (k == 4) in_b = 1'b0;
            exp = {(k >= 6) && (k <= 9), k == 6, k == 10, (k == 6) || (k == 10)};
            checks++;
            if ({out_b, rise_b, fall_b, chg_b} !== exp) begin
                errors++;
                $display("FAIL glitch4 k=%0d {out,rise,fall,chg}=%b required %b", k,
                         {out_b, rise_b, fall_b, chg_b}, exp);
            end
        end
    endtask

    task automatic test_bus_skew();
        logic [24:0] exp;
        in_c = 8'h0F;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 2) in_c = 8'hFF;
            if (k == 7)     exp = {8'hFF, 8'hFF, 8'h00, 1'b1};
            else if (k > 7) exp = {8'hFF, 8'h00, 8'h00, 1'b0};
            else            exp = {8'h00, 8'h00, 8'h00, 1'b0};
            checks++;
            if ({out_c, rise_c, fall_c, chg_c} !== exp) begin
                errors++;
                $display("FAIL bus_skew k=%0d out=%h rise=%h fall=%h chg=%b required %h", k,
                         out_c, rise_c, fall_c, chg_c, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp;
        in_d = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            checks++;
            if ({out_d, rise_d, fall_d, chg_d} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_mid_pre k=%0d {out,rise,fall,chg}=%b required 0000", k,
                         {out_d, rise_d, fall_d, chg_d});
            end
        end
        rst_d = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if ({out_d, rise_d, fall_d, chg_d} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_mid_hold k=%0d {out,rise,fall,chg}=%b required 0000", k,
                         {out_d, rise_d, fall_d, chg_d});
            end
        end
        rst_d = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            tick();
            exp = {k >= 8, k == 8, 1'b0, k == 8};
            checks++;
            if ({out_d, rise_d, fall_d, chg_d} !== exp) begin
                errors++;
                $display("FAIL reset_mid_post k=%0d {out,rise,fall,chg}=%b required %b", k,
                         {out_d, rise_d, fall_d, chg_d}, exp);
            end
        end
    endtask

    // Unfiltered, STAGES=3: out after edge k equals the value driven after edge k-4.
    task automatic test_unfiltered_sweep();
        logic [3:0]  vals [0:47];
        logic [3:0]  exp_out, exp_prev;
        logic [12:0] exp;
        for (int i = 0; i < 48; i++) vals[i] = 4'($urandom);
        exp_prev = 4'h0;
        for (int k = 0; k < 44; k++) begin
            in_e = vals[k];
            tick();
            exp_out = (k >= 3) ? vals[k-3] : 4'h0;
            exp = {exp_out, exp_out & ~exp_prev, ~exp_out & exp_prev, exp_out != exp_prev};
            checks++;
            if ({out_e, rise_e, fall_e, chg_e} !== exp) begin
                errors++;
                $display("FAIL sweep k=%0d {out,rise,fall,chg}=%b required %b", k,
                         {out_e, rise_e, fall_e, chg_e}, exp);
            end
            exp_prev = exp_out;
        end
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; rst_d = 1'b1; rst_e = 1'b1;
        in_a = 4'b1010; in_b = 1'b0; in_c = 8'h00; in_d = 1'b0; in_e = 4'h0;
        test_reset();
        test_simultaneous();
        test_latency();
        test_glitch();
        test_bus_skew();
        test_reset_mid();
        test_unfiltered_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
